controle_memoria_principal: RTL

CONTROLE_MEMORIA_PRINCIPAL -- requirements
Module: controle_memoria_principal

---
 rtl/controle_memoria_principal.sv | 96 +++++++++
 1 files changed

// File: rtl/controle_memoria_principal.sv
// Main-memory controller for a small cache: one write-back and/or one block fill per request.
// Define MEM_INIT_EN to power the array up with mem[i] = i; otherwise it powers up as zeros.
module controle_memoria_principal #(
  parameter int LATENCIA = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       solicitacao_de_escrita_na_memoria,
  input  logic       solicitacao_de_leitura_na_memoria,
  input  logic [4:0] endereco_escrita,
  input  logic [4:0] endereco_leitura,
  input  logic [4:0] bloco_a_ser_escrito_na_memoria,
  output logic [4:0] bloco_lido_da_memoria,
  output logic       ocupado,
  output logic       pronto
);

  typedef enum logic [1:0] {OCIOSO, ESCREVENDO, LENDO, CONCLUIDO} estado_t;

  localparam logic [3:0] RECARGA = 4'(LATENCIA - 1);

`ifdef MEM_INIT_EN
  localparam logic [4:0] VALOR_INICIAL [32] = '{
    5'd0,  5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7,
    5'd8,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15,
    5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
    5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31};
`else
  localparam logic [4:0] VALOR_INICIAL [32] = '{default: 5'd0};
`endif

  logic [4:0] mem [32] = VALOR_INICIAL;

  estado_t    estado, proximo;
  logic [3:0] contador;
  logic       pend_escrita, pend_leitura;
  logic [4:0] end_escrita_reg, end_leitura_reg, dado_escrita_reg;
  logic       aceita, fim_fase, recarrega;

  assign aceita    = (estado == OCIOSO) &&
                     (solicitacao_de_escrita_na_memoria || solicitacao_de_leitura_na_memoria);
  assign fim_fase  = (contador == 4'd0);
  assign recarrega = (estado != proximo) && (proximo == ESCREVENDO || proximo == LENDO);
  assign ocupado   = (estado != OCIOSO);
  assign pronto    = (estado == CONCLUIDO);

  // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:     if (aceita)
                    proximo = solicitacao_de_escrita_na_memoria ? ESCREVENDO : LENDO;
      ESCREVENDO: if (fim_fase) proximo = pend_leitura ? LENDO : CONCLUIDO;
      LENDO:      if (fim_fase) proximo = CONCLUIDO;
      CONCLUIDO:  proximo = OCIOSO;
      default:    proximo = OCIOSO;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado                <= OCIOSO;
      contador              <= 4'd0;
      pend_escrita          <= 1'b0;
      pend_leitura          <= 1'b0;
      end_escrita_reg       <= 5'd0;
      end_leitura_reg       <= 5'd0;
      dado_escrita_reg      <= 5'd0;
      bloco_lido_da_memoria <= 5'd0;
    end else begin
      estado <= proximo;
      if (aceita) begin
        pend_escrita     <= solicitacao_de_escrita_na_memoria;
        pend_leitura     <= solicitacao_de_leitura_na_memoria;
        end_escrita_reg  <= endereco_escrita;
        end_leitura_reg  <= endereco_leitura;
        dado_escrita_reg <= bloco_a_ser_escrito_na_memoria;
      end
      if (recarrega)
        contador <= RECARGA;
      else if (!fim_fase)
        contador <= contador - 4'd1;
      // Sampled on the edge leaving LENDO, after any preceding write has committed.
      if (estado == LENDO && fim_fase)
        bloco_lido_da_memoria <= mem[end_leitura_reg];
    end
  end

  // NOTE: the array has no reset; reset only suppresses a pending commit so aborted writes are lost.
  always_ff @(posedge clock) begin
    if (!reset && estado == ESCREVENDO && fim_fase)
      mem[end_escrita_reg] <= dado_escrita_reg;
  end

endmodule
